// File: rtl/trace_recorder_pkg.sv
// Shared types and entry layout for the trace recorder.
// Entries are packed {cycle, w, trig} so dumps line up with proof counterexample traces.
package trace_recorder_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, POST, READ} state_t;

  localparam int W_WIDTH_DEF  = 3;
  localparam int DEPTH_DEF    = 16;
  localparam int POST_LEN_DEF = 8;
  localparam int CYC_W_DEF    = 32;

  localparam int ENTRY_W  = CYC_W_DEF + W_WIDTH_DEF + 1;
  localparam int TRIG_OFS = 0;
  localparam int W_OFS    = 1;

  function automatic int entry_w(input int cyc_w, input int w_width);
    return cyc_w + w_width + 1;
  endfunction

  function automatic int cyc_ofs(input int w_width);
    return w_width + 1;
  endfunction

endpackage

// File: rtl/trace_recorder_if.sv
// Capture inputs and readout stream of the trace recorder.
interface trace_recorder_if import trace_recorder_pkg::*; #(
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int CYC_W   = CYC_W_DEF
);
  logic [W_WIDTH-1:0] w;
  logic               arm;
  logic               trig;
  logic               rd_valid;
  logic               rd_ready;
  logic [W_WIDTH-1:0] rd_data;
  logic [CYC_W-1:0]   rd_cycle;
  logic               rd_trig;
  logic               rd_last;
  logic               busy;
  logic               done;

  modport master (
    output w, arm, trig, rd_ready,
    input  rd_valid, rd_data, rd_cycle, rd_trig, rd_last, busy, done
  );

  modport slave (
    input  w, arm, trig, rd_ready,
    output rd_valid, rd_data, rd_cycle, rd_trig, rd_last, busy, done
  );
endinterface

// File: rtl/trace_recorder_ram.sv
// Simple dual-port trace storage: synchronous write, registered read that holds when rd_en=0.
module trace_recorder_ram import trace_recorder_pkg::*; #(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ENTRY_W = entry_w(CYC_W_DEF, W_WIDTH_DEF)
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]       wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [ENTRY_W-1:0]       rd_data
);
  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/trace_recorder.sv
// Circular trace capture with trigger plus post-trigger window, then oldest-first
// streaming readout; the RAM read register doubles as the output register.
module trace_recorder import trace_recorder_pkg::*; #(
  parameter int W_WIDTH  = W_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int POST_LEN = POST_LEN_DEF,
  parameter int CYC_W    = CYC_W_DEF
) (
  input logic             clk,
  input logic             rst,
  trace_recorder_if.slave tr
);
  localparam int AW     = $clog2(DEPTH);
  localparam int E_W    = entry_w(CYC_W, W_WIDTH);
  localparam int C_OFS  = cyc_ofs(W_WIDTH);
  localparam logic [AW-1:0] POST_INIT = AW'(POST_LEN);
  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state, state_nx;
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_addr, post_cnt;
  logic [AW:0]      fill, idx_p1;
  logic [CYC_W-1:0] cyc;
  logic             vld_p1, done_q;
  logic             wr_en, rd_en, first_rd, accept, last_p1, accept_last;
  logic [E_W-1:0]   wr_entry, rd_entry;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tr.arm)  state_nx = ARMED;
      ARMED:   if (tr.trig) state_nx = (POST_LEN == 0) ? READ : POST;
      POST:    if (post_cnt == AW'(1)) state_nx = READ;
      READ:    if (accept_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    wr_en       = (state == ARMED) || (state == POST);
    first_rd    = (state == READ) && !vld_p1;
    accept      = vld_p1 && tr.rd_ready;
    last_p1     = vld_p1 && (idx_p1 == fill - 1'b1);
    accept_last = accept && last_p1;
    rd_en       = first_rd || (accept && !last_p1);
    rd_addr     = first_rd ? (wr_ptr - fill[AW-1:0]) : rd_ptr;
    wr_entry    = {cyc, tr.w, (state == ARMED) && tr.trig};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill     <= '0;
      cyc      <= '0;
      post_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (tr.arm) begin
          wr_ptr <= '0;
          fill   <= '0;
          cyc    <= '0;
        end
        ARMED, POST: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != FULL) fill <= fill + 1'b1;
          cyc <= sat_inc(cyc);
          if (state == ARMED && tr.trig) post_cnt <= POST_INIT;
          else if (state == POST)        post_cnt <= post_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  trace_recorder_ram #(.DEPTH(DEPTH), .ENTRY_W(E_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_entry)
  );

  // Stage p1: registered RAM read feeds the output directly
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
      rd_ptr <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= accept_last;
      if (rd_en) rd_ptr <= rd_addr + 1'b1;
      if (first_rd) begin
        vld_p1 <= 1'b1;
        idx_p1 <= '0;
      end else if (accept) begin
        if (last_p1) vld_p1 <= 1'b0;
        else         idx_p1 <= idx_p1 + 1'b1;
      end
    end
  end

  assign tr.rd_valid = vld_p1;
  assign tr.rd_data  = vld_p1 ? rd_entry[W_OFS +: W_WIDTH] : '0;
  assign tr.rd_cycle = vld_p1 ? rd_entry[C_OFS +: CYC_W] : '0;
  assign tr.rd_trig  = vld_p1 & rd_entry[TRIG_OFS];
  assign tr.rd_last  = last_p1;
  assign tr.busy     = (state != IDLE);
  assign tr.done     = done_q;
endmodule
